alu_op_issue: RTL and testbench

//  Producer side of the 4-bit ALU Operation interface, sitting at the ID->EX boundary.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_decode.sv | 68 ++++++
 rtl/alu_op_issue.sv | 78 +++++++
 tb/tb_alu_op_issue.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and decode constants
// for the ID->EX operation interface.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0010,
    OP_ADD = 4'b0100,
    OP_SUB = 4'b0101,
    OP_EQ  = 4'b1000,
    OP_NE  = 4'b1001,
    OP_LT  = 4'b1010,
    OP_GE  = 4'b1011,
    OP_SLL = 4'b1100,
    OP_SRL = 4'b1101,
    OP_SRA = 4'b1110,
    OP_ILL = 4'b1111
  } alu_opcode_t;

  localparam logic [1:0] ALU_LDST = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_R    = 2'b10;
  localparam logic [1:0] ALU_I    = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7 decode into
// the ALU operation code plus an illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output alu_opcode_t operation,
  output logic        illegal
);

  logic base;
  logic alt;
  logic imm;

  assign base = funct7 == F7_BASE;
  assign alt  = funct7 == F7_ALT;
  assign imm  = alu_op == ALU_I;

  always_comb begin
    operation = OP_ILL;
    unique case (1'b1)
      (alu_op == ALU_LDST): operation = OP_ADD;
      (alu_op == ALU_BR): begin
        case (funct3)
          3'b000:  operation = OP_EQ;
          3'b001:  operation = OP_NE;
          3'b100:  operation = OP_LT;
          3'b101:  operation = OP_GE;
          default: operation = OP_ILL;
        endcase
      end
      default: begin
        // immediates carry imm bits in funct7
        // except for the shift encodings
        case (funct3)
          3'b000: begin
            if (imm || base)
              operation = OP_ADD;
            else if (alt)
              operation = OP_SUB;
          end
          3'b111:
            if (imm || base) operation = OP_AND;
          3'b110:
            if (imm || base) operation = OP_OR;
          3'b100:
            if (imm || base) operation = OP_XOR;
          3'b010:
            if (imm || base) operation = OP_LT;
          3'b001:
            if (base) operation = OP_SLL;
          3'b101: begin
            if (base)
              operation = OP_SRL;
            else if (alt)
              operation = OP_SRA;
          end
          default: operation = OP_ILL;
        endcase
      end
    endcase
  end

  assign illegal = operation == OP_ILL;

endmodule

// File: rtl/alu_op_issue.sv
// ID->EX operation slot: decode, one-entry
// valid/ready register, flush and illegal counter.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5,
  parameter int ILL_CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [DATA_WIDTH-1:0]    src_a_i,
  input  logic [DATA_WIDTH-1:0]    src_b_i,
  input  logic [REG_ADDR_W-1:0]    rd_i,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] operation,
  output logic [DATA_WIDTH-1:0]    src_a_o,
  output logic [DATA_WIDTH-1:0]    src_b_o,
  output logic [REG_ADDR_W-1:0]    rd_o,
  output logic                     illegal_o,
  output logic [ILL_CNT_W-1:0]     ill_count
);

  localparam logic [OPCODE_LENGTH-1:0] ILL_CODE =
    OPCODE_LENGTH'(OP_ILL);

  alu_opcode_t dec_op;
  logic        dec_ill;
  logic        accept;
  logic        cnt_full;

  alu_op_decode u_dec (
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .operation (dec_op),
    .illegal   (dec_ill)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cnt_full = &ill_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      operation <= ILL_CODE;
      src_a_o   <= '0;
      src_b_o   <= '0;
      rd_o      <= '0;
      illegal_o <= 1'b0;
      ill_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      operation <= ILL_CODE;
    end else if (accept) begin
      out_valid <= 1'b1;
      operation <= OPCODE_LENGTH'(dec_op);
      src_a_o   <= src_a_i;
      src_b_o   <= src_b_i;
      rd_o      <= rd_i;
      illegal_o <= dec_ill;
      if (dec_ill && !cnt_full)
        ill_count <= ill_count + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized self-checking bench for alu_op_issue
// against a table-level decode and slot model.
module tb_alu_op_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic [4:0]  rd_i;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  operation;
  logic [31:0] src_a_o;
  logic [31:0] src_b_o;
  logic [4:0]  rd_o;
  logic        illegal_o;
  logic [7:0]  ill_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [3:0]  s_operation;
  logic [31:0] s_src_a_o;
  logic [31:0] s_src_b_o;
  logic [4:0]  s_rd_o;
  logic        s_illegal_o;
  logic [1:0]  s_ill_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int exp_cnt2 = 0;

  alu_op_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .src_a_i   (src_a_i),
    .src_b_i   (src_b_i),
    .rd_i      (rd_i),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operation (operation),
    .src_a_o   (src_a_o),
    .src_b_o   (src_b_o),
    .rd_o      (rd_o),
    .illegal_o (illegal_o),
    .ill_count (ill_count)
  );

  alu_op_issue #(.ILL_CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .src_a_i   (src_a_i),
    .src_b_i   (src_b_i),
    .rd_i      (rd_i),
    .flush     (flush),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .operation (s_operation),
    .src_a_o   (s_src_a_o),
    .src_b_o   (s_src_b_o),
    .rd_o      (s_rd_o),
    .illegal_o (s_illegal_o),
    .ill_count (s_ill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written straight from the
  // instruction-class tables.
  function automatic logic [3:0] ref_op(
    input logic [1:0] op,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    bit b;
    bit a;
    b = (f7 == 7'h00);
    a = (f7 == 7'h20);
    if (op == 2'd0) return 4'b0100;
    if (op == 2'd1) begin
      if (f3 == 3'd0) return 4'b1000;
      if (f3 == 3'd1) return 4'b1001;
      if (f3 == 3'd4) return 4'b1010;
      if (f3 == 3'd5) return 4'b1011;
      return 4'b1111;
    end
    if (f3 == 3'd1) return b ? 4'b1100 : 4'b1111;
    if (f3 == 3'd5)
      return b ? 4'b1101 : (a ? 4'b1110 : 4'b1111);
    if (f3 == 3'd3) return 4'b1111;
    if (op == 2'd2 && !b) begin
      if (f3 == 3'd0 && a) return 4'b0101;
      return 4'b1111;
    end
    if (f3 == 3'd0) return 4'b0100;
    if (f3 == 3'd7) return 4'b0000;
    if (f3 == 3'd6) return 4'b0001;
    if (f3 == 3'd4) return 4'b0010;
    return 4'b1010;
  endfunction

  task automatic drive(
    input logic [1:0] op,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    in_valid = 1'b1;
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    src_a_i  = $urandom;
    src_b_i  = $urandom;
    rd_i     = 5'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    alu_op = 2'd0;
    funct3 = 3'd0;
    funct7 = 7'd0;
    src_a_i = '0;
    src_b_i = '0;
    rd_i = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    exp_cnt = 0;
    exp_cnt2 = 0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || operation !== 4'hf ||
        ill_count !== 8'd0 || in_ready !== 1'b1 ||
        src_a_o !== 32'd0 || rd_o !== 5'd0 ||
        illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: v=%b op=%h cnt=%0d rdy=%b a=%h rd=%0d ill=%b required v=0 op=f cnt=0 rdy=1 a=0 rd=0 ill=0",
        out_valid, operation, ill_count, in_ready,
        src_a_o, rd_o, illegal_o);
    end
  endtask

  task automatic test_sweep();
    logic [6:0] f7s [3];
    logic [3:0] e;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [4:0] er;
    f7s[0] = 7'h00;
    f7s[1] = 7'h20;
    f7s[2] = 7'h01;
    out_ready = 1'b1;
    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int k = 0; k < 3; k++) begin
          drive(2'(op), 3'(f3), f7s[k]);
          e = ref_op(2'(op), 3'(f3), f7s[k]);
          ea = src_a_i;
          eb = src_b_i;
          er = rd_i;
          if (e == 4'hf) begin
            exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
          end
          tick();
          checks++;
          if (out_valid !== 1'b1 || operation !== e ||
              illegal_o !== (e == 4'hf) ||
              src_a_o !== ea || src_b_o !== eb ||
              rd_o !== er ||
              ill_count !== 8'(exp_cnt) ||
              s_ill_count !== 2'(exp_cnt2)) begin
            errors++;
            $display("FAIL sweep %0d/%0d/%h: v=%b op=%h ill=%b a=%h b=%h rd=%0d cnt=%0d/%0d required op=%h a=%h b=%h rd=%0d cnt=%0d/%0d",
              op, f3, f7s[k], out_valid, operation,
              illegal_o, src_a_o, src_b_o, rd_o,
              ill_count, s_ill_count, e, ea, eb, er,
              exp_cnt, exp_cnt2);
          end
          if (op == 2 && f3 == 0 && k == 1) begin
            checks++;
            if (operation !== 4'b0101) begin
              errors++;
              $display("FAIL r_sub: op=%h required 5",
                operation);
            end
          end
          if (op == 3 && f3 == 0 && k == 1) begin
            checks++;
            if (operation !== 4'b0100) begin
              errors++;
              $display("FAIL i_add_alt: op=%h required 4",
                operation);
            end
          end
          if (op == 2 && f3 == 3) begin
            checks++;
            if (operation !== 4'hf || illegal_o !== 1'b1) begin
              errors++;
              $display("FAIL r_f3_011: op=%h ill=%b required f/1",
                operation, illegal_o);
            end
          end
        end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] a1;
    logic [4:0] r1;
    logic [31:0] a2;
    logic [4:0] r2;
    out_ready = 1'b1;
    drive(2'd0, 3'($urandom), 7'($urandom));
    a1 = src_a_i;
    r1 = rd_i;
    tick();
    drive(2'd2, 3'd0, 7'h20);
    a2 = src_a_i;
    r2 = rd_i;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready %0d: in_ready=%b required 0",
          i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || operation !== 4'b0100 ||
          src_a_o !== a1 || rd_o !== r1) begin
        errors++;
        $display("FAIL stall_hold %0d: v=%b op=%h a=%h rd=%0d required 1/4/%h/%0d",
          i, out_valid, operation, src_a_o, rd_o, a1, r1);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || operation !== 4'b0100) begin
      errors++;
      $display("FAIL stall_release: rdy=%b op=%h required 1/4",
        in_ready, operation);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || operation !== 4'b0101 ||
        src_a_o !== a2 || rd_o !== r2) begin
      errors++;
      $display("FAIL stall_next: v=%b op=%h a=%h rd=%0d required 1/5/%h/%0d",
        out_valid, operation, src_a_o, rd_o, a2, r2);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || src_a_o !== a2) begin
      errors++;
      $display("FAIL drain: v=%b a=%h required 0/%h",
        out_valid, src_a_o, a2);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(2'd2, 3'd3, 7'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || operation !== 4'hf ||
        ill_count !== 8'(exp_cnt) ||
        s_ill_count !== 2'(exp_cnt2)) begin
      errors++;
      $display("FAIL flush_accept: v=%b op=%h cnt=%0d required 0/f/%0d",
        out_valid, operation, ill_count, exp_cnt);
    end
    drive(2'd1, 3'd1, 7'($urandom));
    tick();
    drive(2'd1, 3'd0, 7'($urandom));
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || operation !== 4'hf) begin
      errors++;
      $display("FAIL flush_stall: v=%b op=%h required 0/f",
        out_valid, operation);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_counter();
    test_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(2'd1, 3'd2, 7'($urandom));
      tick();
      checks++;
      if (s_ill_count !== 2'((i < 3) ? i : 3) ||
          ill_count !== 8'(i) || s_illegal_o !== 1'b1) begin
        errors++;
        $display("FAIL counter %0d: small=%0d big=%0d ill=%b required %0d/%0d/1",
          i, s_ill_count, ill_count, s_illegal_o,
          (i < 3) ? i : 3, i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(2'd2, 3'd5, 7'h20);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || operation !== 4'b1110) begin
      errors++;
      $display("FAIL sra_load: v=%b op=%h required 1/e",
        out_valid, operation);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || operation !== 4'hf ||
        ill_count !== 8'd0 || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: v=%b op=%h cnt=%0d required 0/f/0",
        out_valid, operation, ill_count);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_stall();
    test_flush();
    test_counter();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule
